// File: rtl/soc_pkg.sv
// Shared definitions for the ROM read arbiter.
//   rom_arb_state_e : arbiter FSM states (IDLE -> DATA -> RESP)
//   RESP_OKAY/RESP_SLVERR : AXI-style read response codes
//   idx_w()         : index width for a requester count (at least 1 bit)
package soc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } rom_arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_rr_pick.sv
// Combinational round-robin picker.
//   req_i     : request vector, one bit per requester
//   pointer_i : index the search starts from (highest priority)
//   grant_o   : one-hot grant of the first requesting index at or after pointer_i
//   index_o   : binary index of the granted requester
//   any_o     : at least one request present
module rom_rr_pick
  import soc_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      pointer_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      index_o,
  output logic               any_o
);

  // One extra bit so pointer + offset cannot overflow before the wrap.
  logic [IW:0] w_cand;

  always_comb begin
    grant_o = '0;
    index_o = '0;
    any_o   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, pointer_i} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IW+1)'(NUM_REQ);
      end
      if (!any_o && req_i[w_cand[IW-1:0]]) begin
        any_o                      = 1'b1;
        index_o                    = w_cand[IW-1:0];
        grant_o[w_cand[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arb.sv
// Round-robin read arbiter in front of a single-port 64-bit ROM.
// One transaction in flight at a time: grant in IDLE, capture memory data
// in DATA, present the response in RESP until the granted requester accepts.
//   clk_i, arst_ni  : clock, synchronous active-low reset
//   ar_valid_i/ar_addr_i/ar_prot_i/ar_ready_o : per-requester read address channel
//   r_valid_o/r_ready_i : per-requester response handshake
//   r_data_o/r_resp_o   : shared response data and code (OKAY / SLVERR)
//   mem_req_o/mem_addr_o/mem_rdata_i : ROM port, data returns one cycle after strobe
module rom_read_arb
  import soc_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic [NUM_REQ-1:0]                   ar_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [NUM_REQ-1:0][2:0]              ar_prot_i,
  output logic [NUM_REQ-1:0]                   ar_ready_o,
  output logic [NUM_REQ-1:0]                   r_valid_o,
  output logic [DATA_WIDTH-1:0]                r_data_o,
  output logic [1:0]                           r_resp_o,
  input  logic [NUM_REQ-1:0]                   r_ready_i,
  output logic                                 mem_req_o,
  output logic [ADDR_WIDTH-3:0]                mem_addr_o,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

  localparam int IW = idx_w(NUM_REQ);

  rom_arb_state_e r_state, w_state_nxt;
  logic [IW-1:0]  r_ptr, w_ptr_nxt;
  logic [IW-1:0]  r_idx;
  logic           r_err;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_gidx;
  logic                  w_any;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_prot;
  logic                  w_misaligned;
  logic                  w_take;
  logic                  w_unused_prot;

  rom_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i     (ar_valid_i),
    .pointer_i (r_ptr),
    .grant_o   (w_grant),
    .index_o   (w_gidx),
    .any_o     (w_any)
  );

  assign w_addr        = ar_addr_i[w_gidx];
  assign w_prot        = ar_prot_i[w_gidx];
  assign w_misaligned  = (w_addr[2:0] != 3'b000);
  // Only prot[1] (bank select) matters to a ROM.
  assign w_unused_prot = w_prot[0] ^ w_prot[2];

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_data_o <= '0;
      r_resp_o <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_take) begin
        r_idx <= w_gidx;
        r_err <= w_misaligned;
      end
      if (r_state == ST_DATA) begin
        // A misaligned request never strobed memory, so mem_rdata_i is stale.
        r_data_o <= r_err ? '0 : mem_rdata_i;
        r_resp_o <= r_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_take      = 1'b0;
    ar_ready_o  = '0;
    r_valid_o   = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_take      = 1'b1;
          ar_ready_o  = w_grant;
          w_state_nxt = ST_DATA;
          if (!w_misaligned) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {w_prot[1], w_addr[ADDR_WIDTH-1:3]};
          end
        end
      end
      ST_DATA: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        r_valid_o[r_idx] = 1'b1;
        if (r_ready_i[r_idx]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_idx == IW'(NUM_REQ-1)) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Handshake outputs are forced quiet for as long as reset is held.
    if (!arst_ni) begin
      ar_ready_o = '0;
      r_valid_o  = '0;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
    end
  end

endmodule

// File: tb/tb_rom_read_arb.sv
module tb_rom_read_arb;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 64;

  logic                 clk_i = 1'b0;
  logic                 arst_ni;
  logic [N-1:0]         ar_valid;
  logic [N-1:0][AW-1:0] ar_addr;
  logic [N-1:0][2:0]    ar_prot;
  logic [N-1:0]         ar_ready_o;
  logic [N-1:0]         r_valid_o;
  logic [DW-1:0]        r_data_o;
  logic [1:0]           r_resp_o;
  logic [N-1:0]         r_ready;
  logic                 mem_req_o;
  logic [AW-3:0]        mem_addr_o;
  logic [DW-1:0]        mem_rdata;

  int total = 0;
  int bad   = 0;

  rom_read_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .ar_valid_i  (ar_valid),
    .ar_addr_i   (ar_addr),
    .ar_prot_i   (ar_prot),
    .ar_ready_o  (ar_ready_o),
    .r_valid_o   (r_valid_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_ready_i   (r_ready),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] memword(logic [9:0] w);
    return {32'hC0DE_0000 | 32'(w), ~{22'h0, w}};
  endfunction

  // ROM model: word returned one cycle after the strobe, garbage otherwise.
  always @(posedge clk_i)
    mem_rdata <= mem_req_o ? memword(mem_addr_o) : 64'hDEAD_DEAD_DEAD_DEAD;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Transaction-level reference: who is served, when the response shows up.
  bit          m_busy = 0;
  int          m_ptr  = 0;
  int          m_idx  = 0;
  int          m_age  = 0;
  logic [63:0] m_data = '0;
  logic [1:0]  m_resp = '0;

  always @(negedge clk_i) begin
    logic [N-1:0] e_ready, e_rv;
    logic         e_req;
    logic [9:0]   e_maddr;
    int           g;
    e_ready = '0; e_rv = '0; e_req = 1'b0; e_maddr = '0; g = -1;
    if (!arst_ni) begin
      chk("rst_ready", 64'(ar_ready_o), 64'(0));
      chk("rst_rvalid", 64'(r_valid_o), 64'(0));
      chk("rst_memreq", 64'(mem_req_o), 64'(0));
      chk("rst_maddr", 64'(mem_addr_o), 64'(0));
      m_busy = 0;
      m_ptr  = 0;
    end else begin
      if (!m_busy) begin
        g = rr(ar_valid, m_ptr);
        if (g >= 0) begin
          e_ready = N'(1 << g);
          e_req   = (ar_addr[g][2:0] == 3'b000);
          e_maddr = {ar_prot[g][1], ar_addr[g][11:3]};
        end
      end else if (m_age >= 2) begin
        e_rv = N'(1 << m_idx);
      end
      chk("m_ready", 64'(ar_ready_o), 64'(e_ready));
      chk("m_rvalid", 64'(r_valid_o), 64'(e_rv));
      chk("m_memreq", 64'(mem_req_o), 64'(e_req));
      if (e_req) chk("m_maddr", 64'(mem_addr_o), 64'(e_maddr));
      if (e_rv != '0) begin
        chk("m_rdata", r_data_o, m_data);
        chk("m_rresp", 64'(r_resp_o), 64'(m_resp));
      end
      if (g >= 0) begin
        m_busy = 1;
        m_idx  = g;
        m_age  = 1;
        m_data = e_req ? memword(e_maddr) : 64'h0;
        m_resp = e_req ? 2'd0 : 2'd2;
      end else if (m_busy) begin
        if (m_age >= 2 && r_ready[m_idx]) begin
          m_busy = 0;
          m_ptr  = (m_idx + 1) % N;
        end else begin
          m_age++;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  int grants[$];
  int gtime[$];

  initial begin
    arst_ni  = 1'b0;
    ar_valid = '0;
    ar_addr  = '0;
    ar_prot  = '0;
    r_ready  = '1;
    tick(3);
    chk("rst_rdata", r_data_o, 64'h0);
    chk("rst_rresp", 64'(r_resp_o), 64'(0));
    arst_ni = 1'b1;
    tick(1);

    // Aligned read, requester 0, word 1.
    ar_valid = 2'b01; ar_addr[0] = 12'h008; ar_prot[0] = 3'b000;
    @(negedge clk_i);
    chk("d1_ready", 64'(ar_ready_o), 64'(2'b01));
    chk("d1_memreq", 64'(mem_req_o), 64'(1));
    chk("d1_maddr", 64'(mem_addr_o), 64'h001);
    tick(1); ar_valid = '0;
    @(negedge clk_i);
    chk("d1_n1_rvalid", 64'(r_valid_o), 64'(0));
    @(negedge clk_i);
    chk("d1_n2_rvalid", 64'(r_valid_o), 64'(2'b01));
    chk("d1_data", r_data_o, memword(10'd1));
    chk("d1_resp", 64'(r_resp_o), 64'(0));
    tick(2);

    // Misaligned read, requester 1.
    ar_valid = 2'b10; ar_addr[1] = 12'h00C; ar_prot[1] = 3'b000;
    @(negedge clk_i);
    chk("d2_ready", 64'(ar_ready_o), 64'(2'b10));
    chk("d2_memreq", 64'(mem_req_o), 64'(0));
    tick(1); ar_valid = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("d2_rvalid", 64'(r_valid_o), 64'(2'b10));
    chk("d2_resp", 64'(r_resp_o), 64'(2));
    chk("d2_data", r_data_o, 64'h0);
    tick(2);

    // Bank select via prot[1].
    ar_valid = 2'b01; ar_addr[0] = 12'h010; ar_prot[0] = 3'b010;
    @(negedge clk_i);
    chk("d3_maddr", 64'(mem_addr_o), 64'h202);
    tick(1); ar_valid = '0;
    tick(3);

    // Back-pressure on the response.
    r_ready = 2'b00;
    ar_valid = 2'b01; ar_addr[0] = 12'h018; ar_prot[0] = 3'b000;
    @(negedge clk_i);
    tick(1); ar_valid = 2'b10; ar_addr[1] = 12'h020;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("d4_hold_rvalid", 64'(r_valid_o), 64'(2'b01));
      chk("d4_hold_data", r_data_o, memword(10'd3));
      chk("d4_hold_ready", 64'(ar_ready_o), 64'(0));
    end
    tick(1); ar_valid = '0; r_ready = 2'b01;
    @(negedge clk_i);
    chk("d4_hs_rvalid", 64'(r_valid_o), 64'(2'b01));
    @(negedge clk_i);
    chk("d4_after_rvalid", 64'(r_valid_o), 64'(0));
    tick(1); r_ready = 2'b11;
    tick(2);

    // Both requesting continuously: pointer is 1 after serving requester 0.
    ar_addr[0] = 12'h028; ar_addr[1] = 12'h030; ar_prot = '0;
    ar_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (ar_ready_o == 2'b01) begin grants.push_back(0); gtime.push_back(c); end
      if (ar_ready_o == 2'b10) begin grants.push_back(1); gtime.push_back(c); end
    end
    tick(1); ar_valid = '0;
    chk("rr_count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      chk("rr_order", 64'(grants[i]), 64'((i % 2 == 0) ? 1 : 0));
      chk("rr_time", 64'(gtime[i]), 64'(3 * i));
    end
    tick(3);

    // Reset while a response is pending.
    r_ready = 2'b00;
    ar_valid = 2'b01; ar_addr[0] = 12'h040;
    @(negedge clk_i);
    tick(1); ar_valid = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("d5_pre_rvalid", 64'(r_valid_o), 64'(2'b01));
    tick(1); arst_ni = 1'b0;
    tick(1);
    @(negedge clk_i);
    chk("d5_rst_rdata", r_data_o, 64'h0);
    chk("d5_rst_rresp", 64'(r_resp_o), 64'(0));
    tick(1); arst_ni = 1'b1; r_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("d5_no_resp", 64'(r_valid_o), 64'(0));
    end
    tick(1); ar_valid = 2'b11;
    @(negedge clk_i);
    chk("d5_ptr0", 64'(ar_ready_o), 64'(2'b01));
    tick(1); ar_valid = '0;
    tick(4);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      arst_ni  = ($urandom_range(0, 63) != 0);
      ar_valid = N'($urandom);
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 5) == 0) ar_addr[r] = AW'($urandom);
        else ar_addr[r] = {9'($urandom), 3'b000};
        ar_prot[r] = 3'($urandom);
      end
      r_ready = N'($urandom);
      tick(1);
    end
    arst_ni = 1'b1; ar_valid = '0; r_ready = '1;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_read_arb.md
ROM_READ_ARB -- requirements
Module: rom_read_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning number of read requesters (legal range 2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning requester byte-address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 64, meaning memory word width in bits (fixed at 64 for 8-byte words).
REQ-004 The block SHALL have port clk_i, input, 1, meaning the single clock; all logic is rising-edge clocked.
REQ-005 The block SHALL have port arst_ni, input, 1, meaning reset; synchronous, active-low.
REQ-006 The block SHALL have port ar_valid_i, input, NUM_REQ, meaning per-requester read request valid.
REQ-007 The block SHALL have port ar_addr_i, input, NUM_REQ x ADDR_WIDTH, meaning per-requester byte address.
REQ-008 The block SHALL have port ar_prot_i, input, NUM_REQ x 3, meaning per-requester AXI prot; bit 1 selects the memory bank.
REQ-009 The block SHALL have port ar_ready_o, input-accept, output, NUM_REQ, meaning per-requester request accepted.
REQ-010 The block SHALL have port r_valid_o, output, NUM_REQ, meaning per-requester response valid.
REQ-011 The block SHALL have port r_data_o, output, DATA_WIDTH, meaning response data, shared by all requesters.
REQ-012 The block SHALL have port r_resp_o, output, 2, meaning response code: 0 OKAY, 2 SLVERR.
REQ-013 The block SHALL have port r_ready_i, input, NUM_REQ, meaning per-requester response ready.
REQ-014 The block SHALL have port mem_req_o, output, 1, meaning memory read strobe.
REQ-015 The block SHALL have port mem_addr_o, output, ADDR_WIDTH-2, meaning word address {prot[1], addr[ADDR_WIDTH-1:3]}.
REQ-016 The block SHALL have port mem_rdata_i, input, DATA_WIDTH, meaning memory read data, valid one cycle after mem_req_o.

Function
REQ-017 The FSM SHALL have states IDLE, DATA and RESP.
REQ-018 In IDLE, if any ar_valid_i bit is set, the block SHALL grant exactly one requester, chosen round-robin starting from the requester index held in the priority pointer.
REQ-019 The block SHALL assert ar_ready_o only for the granted requester, only in IDLE, and in the same cycle as the grant; it SHALL latch that requester's index, address and prot, then move to DATA.
REQ-020 In the grant cycle, the block SHALL assert mem_req_o and drive mem_addr_o combinationally from the granted address, but only if addr[2:0]==0.
REQ-021 If addr[2:0]!=0 (misaligned), the block SHALL keep mem_req_o low, set the latched response to SLVERR and set r_data to 0.
REQ-022 In DATA, the block SHALL register mem_rdata_i (or 0 if misaligned) into r_data_o and the matching r_resp_o, then move to RESP.
REQ-023 In RESP, the block SHALL hold r_valid_o high for the latched requester only, with r_data_o/r_resp_o stable, until that requester's r_ready_i is high.
REQ-024 On the r handshake, the block SHALL return to IDLE and set the priority pointer to (granted index + 1) mod NUM_REQ.
REQ-025 Latency SHALL be: ar handshake in cycle N gives r_valid_o first high in cycle N+2; peak throughput is one read per 3 cycles.
REQ-026 At most one transaction SHALL be outstanding; ar_ready_o SHALL be all-zero in DATA and RESP.
REQ-027 r_ready_i from non-granted requesters and r_ready_i asserted before RESP SHALL be ignored.
REQ-028 A requester that drops ar_valid_i before being granted SHALL NOT be granted; no request is latched without ar_ready_o.
REQ-029 When the pointer wraps from NUM_REQ-1, the next search SHALL start at index 0.

Reset
REQ-030 While arst_ni is sampled low, the state SHALL go to IDLE, the priority pointer to 0, and ar_ready_o, r_valid_o, mem_req_o, r_data_o, r_resp_o and mem_addr_o SHALL all be 0.
REQ-031 Reset mid-transaction SHALL drop the pending response; no r_valid_o SHALL follow after reset deasserts unless a new request is made.

Structure
REQ-032 The state enum rom_arb_state_e and the response codes SHALL live in soc_pkg.
REQ-033 Round-robin selection SHALL be a combinational sub-module rom_rr_pick with inputs req and pointer, and outputs grant one-hot, index and any.

Verification
REQ-034 Reset, then req0 addr 0x008 prot 0 -> ar_ready_o[0] in the same cycle, mem_addr_o=0x001, r_valid_o[0] at N+2, data=mem word 1, r_resp_o=0.
REQ-035 Both requesters valid continuously, r_ready_i=all-ones -> grants alternate 0,1,0,1, one per 3 cycles.
REQ-036 req1 addr 0x00C -> mem_req_o stays 0, r_resp_o=2, r_data_o=0.
REQ-037 r_ready_i[0] held low 5 cycles in RESP -> r_valid_o[0] and r_data_o stable, no ar_ready_o, single handshake on release.
REQ-038 prot[1]=1, addr 0x010 -> mem_addr_o=0x202 (bank bit set) with ADDR_WIDTH=12.
REQ-039 Reset asserted in RESP -> outputs 0 next cycle, no response after release, pointer back to 0.
